// File: rtl/keynsham_ldst_defs.sv
// Shared definitions for the Keynsham load/store unit: access width
// encodings, FSM state encodings and the default bus timeout.
package keynsham_ldst_defs;

  typedef enum logic [1:0] {
    W_BYTE = 2'b00,
    W_HALF = 2'b01,
    W_WORD = 2'b10,
    W_RSVD = 2'b11
  } width_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STROBE = 3'd1,
    S_WAIT   = 3'd2,
    S_RESP   = 3'd3,
    S_FAULT  = 3'd4
  } state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/keynsham_ldst_align.sv
// Combinational lane logic for the load/store unit: byte-enable generation,
// store-data lane replication, misalignment detection, and load lane
// extraction with zero/sign extension.
module keynsham_ldst_align
  import keynsham_ldst_defs::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  width,
  input  logic [31:0] wr_val,
  output logic [3:0]  bytesel,
  output logic [31:0] wr_rep,
  output logic        misaligned,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_width,
  input  logic        ld_signed,
  input  logic [31:0] ld_data,
  output logic [31:0] ld_val
);

  logic [31:0] shifted;

  // Request side: enables, replicated store data and the alignment check.
  always_comb begin
    bytesel    = 4'b0000;
    wr_rep     = 32'h0;
    misaligned = 1'b0;
    case (width)
      W_BYTE: begin
        bytesel = 4'b0001 << addr_lo;
        wr_rep  = {4{wr_val[7:0]}};
      end
      W_HALF: begin
        bytesel    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_rep     = {2{wr_val[15:0]}};
        misaligned = addr_lo[0];
      end
      W_WORD: begin
        bytesel    = 4'b1111;
        wr_rep     = wr_val;
        misaligned = |addr_lo;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted = ld_data >> {ld_off, 3'b000};
    case (ld_width)
      W_BYTE:  ld_val = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
      W_HALF:  ld_val = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
      default: ld_val = shifted;
    endcase
  end

endmodule

// File: rtl/keynsham_ldst.sv
// Keynsham load/store unit. Turns one execute-stage request into a single
// strobed data-bus transaction and returns aligned, extended load data.
// Handshake: a request is accepted on a cycle where req_valid and req_ready
// are both high; req_ready is high only in IDLE, so at most one request is
// ever in flight. done is a one-cycle pulse, err qualifies it.
// Optional feature: define KEYNSHAM_LDST_TIMEOUT_EN to bound the WAIT state
// by TIMEOUT_CYCLES; without it WAIT holds until d_ack.
module keynsham_ldst
  import keynsham_ldst_defs::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_width,
  input  logic        req_signed,
  input  logic [31:0] req_wr_val,
  output logic        done,
  output logic        err,
  output logic [31:0] rd_val,
  output logic        d_access,
  output logic [31:0] d_addr,
  output logic [3:0]  d_bytesel,
  output logic [31:0] d_wr_val,
  output logic        d_wr_en,
  input  logic [31:0] d_data,
  input  logic        d_ack
);

  state_e      state;
  logic [1:0]  width_q;
  logic [1:0]  off_q;
  logic        signed_q;
  logic        wr_q;
  logic [3:0]  bytesel_c;
  logic [31:0] wr_rep_c;
  logic        mis_c;
  logic [31:0] ld_val_c;
  logic        timeout_hit;

  assign req_ready = (state == S_IDLE);

  keynsham_ldst_align u_align (
    .addr_lo    (req_addr[1:0]),
    .width      (req_width),
    .wr_val     (req_wr_val),
    .bytesel    (bytesel_c),
    .wr_rep     (wr_rep_c),
    .misaligned (mis_c),
    .ld_off     (off_q),
    .ld_width   (width_q),
    .ld_signed  (signed_q),
    .ld_data    (d_data),
    .ld_val     (ld_val_c)
  );

`ifdef KEYNSHAM_LDST_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;

  // The count equals the number of WAIT cycles already spent; the last
  // allowed WAIT cycle is the one where it reaches TIMEOUT_CYCLES-1.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count WAIT cycles, restarting from zero in every STROBE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == S_STROBE) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Main FSM; every output except req_ready is registered on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      done      <= 1'b0;
      err       <= 1'b0;
      rd_val    <= 32'h0;
      d_access  <= 1'b0;
      d_wr_en   <= 1'b0;
      d_addr    <= 32'h0;
      d_bytesel <= 4'b0000;
      d_wr_val  <= 32'h0;
      width_q   <= 2'b00;
      off_q     <= 2'b00;
      signed_q  <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      d_access <= 1'b0;
      d_wr_en  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (mis_c) begin
              // Misaligned requests never reach the bus.
              state  <= S_FAULT;
              done   <= 1'b1;
              err    <= 1'b1;
              rd_val <= 32'h0;
            end else begin
              state     <= S_STROBE;
              d_access  <= 1'b1;
              d_wr_en   <= req_wr;
              d_addr    <= {req_addr[31:2], 2'b00};
              d_bytesel <= bytesel_c;
              d_wr_val  <= wr_rep_c;
              width_q   <= req_width;
              off_q     <= req_addr[1:0];
              signed_q  <= req_signed;
              wr_q      <= req_wr;
            end
          end
        end
        S_STROBE: state <= S_WAIT;
        S_WAIT: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (d_ack) begin
            state  <= S_RESP;
            done   <= 1'b1;
            rd_val <= wr_q ? 32'h0 : ld_val_c;
          end else if (timeout_hit) begin
            state  <= S_FAULT;
            done   <= 1'b1;
            err    <= 1'b1;
            rd_val <= 32'h0;
          end
        end
        S_RESP:  state <= S_IDLE;
        S_FAULT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/keynsham_ldst.md
# keynsham_ldst

Load/store unit for the Keynsham core. Accepts one memory request at a time from the execute stage and converts it into a single data-bus transaction: byte enables, lane-replicated write data and one access strobe. Waits for the bus acknowledge, then returns aligned and extended load data. Sits directly upstream of the on-chip RAM and peripheral decode on the data port.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus cycles to wait for `d_ack` before flagging an error. Used only with the timeout feature; minimum value 2.

- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request; high only in IDLE.
- `req_wr` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_width` in 2: 00 = byte, 01 = half, 10 = word; 11 is reserved and treated as misaligned.
- `req_signed` in 1: sign-extend the load result.
- `req_wr_val` in 32: store data, right-justified.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `done`; request was misaligned or timed out.
- `rd_val` out 32: load result, valid with `done`.
- `d_access` out 1: one-cycle bus strobe.
- `d_addr` out 32: word-aligned address (bits [1:0] = 0).
- `d_bytesel` out 4: byte enables.
- `d_wr_val` out 32: lane-replicated store data.
- `d_wr_en` out 1: write enable, high only in the strobe cycle.
- `d_data` in 32: read data, valid when `d_ack` is high.
- `d_ack` in 1: transaction complete.

## Operation
- Lane convention: the byte at address offset k occupies bits [8k+7:8k].
- Byte enables:
  - byte: `1 << addr[1:0]`.
  - half: `4'b0011` or `4'b1100`, selected by `addr[1]`.
  - word: `4'b1111`.
- Store data is replicated across lanes: byte written to all four lanes, half to both halves.
- Misalignment: half with `addr[0]=1`, word with `addr[1:0]!=0`, or width 11.
  - No bus strobe is issued.
  - Next cycle: `done=1`, `err=1`, `rd_val=0`.
- States:
  - IDLE: on accept (`req_valid & req_ready`) of an aligned request, register the address, bytesel, write data, width, signed flag and lane offset; go to STROBE. On a misaligned request, go to FAULT.
  - STROBE: `d_access=1`, `d_wr_en=req_wr`; go to WAIT.
  - WAIT: `d_access=0`, `d_wr_en=0`; `d_addr`, `d_bytesel` and `d_wr_val` are held stable. On `d_ack`, extract the lane from `d_data`, zero- or sign-extend it into `rd_val`, and go to RESP.
  - RESP: `done=1`, `err=0`; go to IDLE.
  - FAULT: `done=1`, `err=1`; go to IDLE.
- `rd_val` for stores is 0. `rd_val` holds its value until the next `done`.
- `d_ack` is ignored in IDLE, STROBE, RESP and FAULT; a stray or late ack must not corrupt state.
- `d_access` is a single-cycle strobe because the downstream RAM registers its ack from every strobed cycle. A strobe held high would produce a duplicate ack.

## Timing
- Reset values:
  - state = IDLE, so `req_ready=1`.
  - `done`, `err`, `d_access` and `d_wr_en` = 0.
  - `d_addr`, `d_bytesel`, `d_wr_val` and `rd_val` = 0.
- Accept at cycle T:
  - `d_access` is high at T+1.
  - With RAM, `d_ack` arrives at T+2, giving `done` at T+3.
  - Minimum accept-to-`done` latency is 3 cycles. Peak throughput is one request per 4 cycles, because the next accept happens at the first IDLE cycle.
- Misaligned request accepted at T: `done`/`err` at T+1.
- All outputs are registered except `req_ready`, which is decoded from state.
- Reset asserted mid-transaction: the unit returns to IDLE immediately with no `done` pulse. Any subsequent ack is ignored.

## Configuration
- `KEYNSHAM_LDST_TIMEOUT_EN` defined:
  - An 8+-bit counter clears in STROBE and increments each WAIT cycle.
  - When the count reaches `TIMEOUT_CYCLES` with no `d_ack`, go to FAULT (`done=1`, `err=1`, `rd_val=0`).
  - If ack and the timeout land in the same cycle, the ack wins.
- Undefined: WAIT holds indefinitely until `d_ack`, and no counter logic is generated.

## Structure
- Shared package/header `keynsham_ldst_defs` holds:
  - width encodings (BYTE/HALF/WORD);
  - state encodings (IDLE, STROBE, WAIT, RESP, FAULT);
  - the default `TIMEOUT_CYCLES`.
- Sub-module `keynsham_ldst_align` (combinational) contains:
  - bytesel generation;
  - store lane replication;
  - misalignment detect;
  - load lane extraction and extension.
- The parent module holds the FSM, the registers and the timeout counter.

## Test plan
- Word store 0x12345678 to 0x100, then word load from 0x100: bus sees `d_bytesel=1111` and `d_wr_en` for exactly one cycle; the load returns `rd_val=0x12345678` with `done` exactly 3 cycles after accept.
- Byte store 0xAB to 0x103, then signed byte load from 0x103: store sees `d_bytesel=1000` and `d_wr_val=0xABABABAB`; load returns `rd_val=0xFFFFFFAB`. The same load with `req_signed=0` returns 0x000000AB.
- Half load from 0x102, memory word 0x8001_1234, signed: `d_bytesel=1100`, `rd_val=0xFFFF8001`.
- Word load from 0x101: no `d_access` pulse; `done=1`, `err=1` one cycle after accept.
- With `KEYNSHAM_LDST_TIMEOUT_EN` and `TIMEOUT_CYCLES=4`, bus never acks: `done`/`err` appear after 4 WAIT cycles. An ack injected one cycle later is ignored and `req_ready` stays 1.
- `rst_n` pulsed low while in WAIT: `req_ready=1` and all outputs are 0 immediately; the ack arriving after reset produces no `done`.
